hpdl_scan: RTL

HPDL_SCAN -- requirements
Module: hpdl_scan

---
 rtl/hpdl_pkg.sv | 34 +++
 rtl/hpdl_scan_if.sv | 26 ++
 rtl/hpdl_scan.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hpdl_pkg.sv
// Shared types, constants and the character-folding helper for the HPDL-1414 scanner.
// The UART-side buffer logic imports this package to reuse map_char.
package hpdl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      SETUP,
      STROBE,
      HOLD,
      GAP
   } hpdl_state_e;

   localparam int         NUM_POS    = 16;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CASE_FOLD  = 8'h20;

   // Bit 7 is ignored; control codes become blanks and lowercase folds onto the upper half.
   function automatic logic [6:0] map_char(input logic [7:0] raw);
      logic [7:0] c;
      logic [7:0] r;
      c = {1'b0, raw[6:0]};
      if (c < CHAR_SPACE) begin
         r = CHAR_SPACE;
      end else if (c >= 8'h60) begin
         r = c - CASE_FOLD;
      end else begin
         r = c;
      end
      return r[6:0];
   endfunction

endpackage

// File: rtl/hpdl_scan_if.sv
// Buffer read port plus the HPDL-1414 display bus, shared by the scanner and its environment.
interface hpdl_scan_if;

   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [6:0] HPDL_D;
   logic [1:0] HPDL_A;
   logic [3:0] HPDL_WR_N;

   modport master (
      output rd_addr,
      input  rd_data,
      output HPDL_D,
      output HPDL_A,
      output HPDL_WR_N
   );

   modport slave (
      input  rd_addr,
      output rd_data,
      input  HPDL_D,
      input  HPDL_A,
      input  HPDL_WR_N
   );

endinterface

// File: rtl/hpdl_scan.sv
// Continuously scans a 16-byte character buffer onto four HPDL-1414 modules,
// one character per write cycle, with a programmable setup/strobe/hold/gap timeline.
module hpdl_scan
   import hpdl_pkg::*;
#(
   parameter int SETUP_CYC  = 4,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2,
   parameter int GAP_CYC    = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               enable,
   hpdl_scan_if.master        bus,
   output logic               busy,
   output logic               frame_done
);

   localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
   localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC - 1);
   localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYC - 1);
   localparam logic [3:0] LAST_POS    = 4'(NUM_POS - 1);

   hpdl_state_e state_q;
   logic [3:0]  pos_q;
   logic [7:0]  cnt_q;
   logic [6:0]  d_q;
   logic [1:0]  a_q;
   logic [1:0]  sel_q;
   logic [3:0]  wr_n_q;
   logic        busy_q;
   logic        done_q;
   logic        armed_q;

   logic [6:0]  char_d;
   logic [3:0]  strobe_d;
   logic        cnt_zero_d;

   assign char_d     = map_char(bus.rd_data);
   assign strobe_d   = ~(4'b0001 << sel_q);
   assign cnt_zero_d = (cnt_q == 8'd0);

   // armed_q holds off the first FETCH until one clean edge after reset release.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         pos_q   <= 4'd0;
         cnt_q   <= 8'd0;
         d_q     <= CHAR_SPACE[6:0];
         a_q     <= 2'b11;
         sel_q   <= 2'b00;
         wr_n_q  <= 4'b1111;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable && armed_q) begin
                  state_q <= FETCH;
                  pos_q   <= 4'd0;
                  busy_q  <= 1'b1;
               end
            end
            FETCH: begin
               state_q <= LATCH;
            end
            LATCH: begin
               d_q     <= char_d;
               a_q     <= ~pos_q[1:0];
               sel_q   <= pos_q[3:2];
               cnt_q   <= SETUP_LOAD;
               state_q <= SETUP;
            end
            SETUP: begin
               if (cnt_zero_d) begin
                  state_q <= STROBE;
                  cnt_q   <= STROBE_LOAD;
                  wr_n_q  <= strobe_d;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            STROBE: begin
               if (cnt_zero_d) begin
                  state_q <= HOLD;
                  cnt_q   <= HOLD_LOAD;
                  wr_n_q  <= 4'b1111;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            // A dropped enable is only honoured here, so a started strobe always completes.
            HOLD: begin
               if (!cnt_zero_d) begin
                  cnt_q <= cnt_q - 8'd1;
               end else if (!enable) begin
                  state_q <= IDLE;
                  pos_q   <= 4'd0;
                  busy_q  <= 1'b0;
               end else if (pos_q == LAST_POS) begin
                  state_q <= GAP;
                  cnt_q   <= GAP_LOAD;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= FETCH;
                  pos_q   <= pos_q + 4'd1;
               end
            end
            GAP: begin
               if (!cnt_zero_d) begin
                  cnt_q <= cnt_q - 8'd1;
               end else if (enable) begin
                  state_q <= FETCH;
                  pos_q   <= 4'd0;
               end else begin
                  state_q <= IDLE;
                  pos_q   <= 4'd0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               wr_n_q  <= 4'b1111;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_addr   = pos_q;
   assign bus.HPDL_D    = d_q;
   assign bus.HPDL_A    = a_q;
   assign bus.HPDL_WR_N = wr_n_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;

endmodule
